// File: rtl/enigma_pkg.sv
// Shared Enigma types: letter encoding and the key sequencer state set.
package enigma_pkg;

    localparam int unsigned LETTER_W = 5;
    localparam int unsigned ALPHABET = 26;

    typedef logic [LETTER_W-1:0] letter_t;

    typedef enum logic [2:0] {
        KsIdle   = 3'd0,
        KsLoad   = 3'd1,
        KsStep   = 3'd2,
        KsSettle = 3'd3,
        KsStart  = 3'd4,
        KsWait   = 3'd5,
        KsOut    = 3'd6
    } keyseq_state_t;

    function automatic logic letter_ok(letter_t l);
        return l < letter_t'(ALPHABET);
    endfunction

endpackage

// File: rtl/key_sequencer_if.sv
// Keypress input, ciphertext output and cipher datapath handshakes of the key sequencer.
interface key_sequencer_if;
    import enigma_pkg::*;

    logic    in_valid;
    logic    in_ready;
    letter_t in_letter;

    logic    out_valid;
    logic    out_ready;
    letter_t out_letter;

    logic    cipher_start;
    letter_t cipher_letter;
    logic    cipher_done;
    letter_t cipher_result;

    modport master (
        input  in_valid, in_letter, out_ready, cipher_done, cipher_result,
        output in_ready, out_valid, out_letter, cipher_start, cipher_letter
    );

    modport slave (
        output in_valid, in_letter, out_ready, cipher_done, cipher_result,
        input  in_ready, out_valid, out_letter, cipher_start, cipher_letter
    );

endinterface

// File: rtl/key_sequencer.sv
// Per-keypress control: steps the rotors, runs the cipher datapath under a watchdog and
// hands the ciphertext back, counting completed letters.
module key_sequencer
    import enigma_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    key_sequencer_if.master bus,
    input  logic            load_req,
    output logic            load_pulse,
    output logic            step_pulse,
    output logic            busy,
    output logic            err_letter,
    output logic            err_timeout,
    output logic [15:0]     letter_count
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = KsIdle;
    localparam logic [2:0] S_LOAD   = KsLoad;
    localparam logic [2:0] S_STEP   = KsStep;
    localparam logic [2:0] S_SETTLE = KsSettle;
    localparam logic [2:0] S_START  = KsStart;
    localparam logic [2:0] S_WAIT   = KsWait;
    localparam logic [2:0] S_OUT    = KsOut;

    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    letter_t         r_cipher_letter;
    letter_t         r_out_letter;
    logic [15:0]     r_count;
    logic [WD_W-1:0] r_wd;
    logic            r_err_letter;
    logic            r_err_timeout;

    logic w_accept;
    logic w_letter_ok;
    logic w_timeout;

    assign w_accept    = (r_state == S_IDLE) && !load_req && bus.in_valid;
    assign w_letter_ok = letter_ok(bus.in_letter);
    // Done in the expiry cycle wins, so the watchdog only fires without done.
    assign w_timeout   = (r_state == S_WAIT) && !bus.cipher_done && (r_wd == WD_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_req) begin
                    w_state_next = S_LOAD;
                end else if (bus.in_valid && w_letter_ok) begin
                    w_state_next = S_STEP;
                end
            end
            S_LOAD:   w_state_next = S_IDLE;
            S_STEP:   w_state_next = S_SETTLE;
            S_SETTLE: w_state_next = S_START;
            S_START:  w_state_next = S_WAIT;
            S_WAIT: begin
                if (bus.cipher_done) begin
                    w_state_next = S_OUT;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_cipher_letter <= '0;
            r_out_letter    <= '0;
            r_count         <= '0;
            r_wd            <= '0;
            r_err_letter    <= 1'b0;
            r_err_timeout   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_err_letter  <= w_accept && !w_letter_ok;
            r_err_timeout <= w_timeout;
            if (w_accept && w_letter_ok) begin
                r_cipher_letter <= bus.in_letter;
            end
            if (r_state == S_START) begin
                r_wd <= '0;
            end else if (r_state == S_WAIT && !bus.cipher_done) begin
                r_wd <= r_wd + WD_W'(1);
            end
            if (r_state == S_WAIT && bus.cipher_done) begin
                r_out_letter <= bus.cipher_result;
            end
            if (r_state == S_LOAD) begin
                r_count <= '0;
            end else if (r_state == S_OUT && bus.out_ready) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign bus.in_ready      = (r_state == S_IDLE) && !load_req;
    assign bus.out_valid     = (r_state == S_OUT);
    assign bus.out_letter    = r_out_letter;
    assign bus.cipher_start  = (r_state == S_START);
    assign bus.cipher_letter = r_cipher_letter;

    assign load_pulse   = (r_state == S_LOAD);
    assign step_pulse   = (r_state == S_STEP);
    assign busy         = (r_state != S_IDLE);
    assign err_letter   = r_err_letter;
    assign err_timeout  = r_err_timeout;
    assign letter_count = r_count;

endmodule

// File: tb/tb_key_sequencer.sv
// Directed bench for key_sequencer: timing, backpressure, load priority, bad letters,
// watchdog expiry and asynchronous reset.
module tb_key_sequencer;

    logic        clk;
    logic        rst;
    logic        load_req;
    logic        load_pulse;
    logic        step_pulse;
    logic        busy;
    logic        err_letter;
    logic        err_timeout;
    logic [15:0] letter_count;

    int n_vec;
    int n_err;

    key_sequencer_if bus ();

    key_sequencer #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .load_req     (load_req),
        .load_pulse   (load_pulse),
        .step_pulse   (step_pulse),
        .busy         (busy),
        .err_letter   (err_letter),
        .err_timeout  (err_timeout),
        .letter_count (letter_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a letter in the current IDLE cycle and advance to the first WAIT cycle.
    task automatic run_to_wait(input logic [4:0] letter);
        bus.in_valid  = 1'b1;
        bus.in_letter = letter;
        tick();
        bus.in_valid  = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        n_vec             = 0;
        n_err             = 0;
        rst               = 1'b0;
        load_req          = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_letter     = '0;
        bus.out_ready     = 1'b0;
        bus.cipher_done   = 1'b0;
        bus.cipher_result = '0;

        #3 rst = 1'b1;
        #4;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_count", 32'(letter_count), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_letter", 32'(bus.out_letter), 32'd0);
        chk("rst_cipher_letter", 32'(bus.cipher_letter), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // First letter: A, result 1 from a datapath answering one cycle after start.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_letter = 5'd0;
        #1 chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("t1_c1_step", 32'(step_pulse), 32'd1);
        chk("t1_c1_busy", 32'(busy), 32'd1);
        chk("t1_c1_cstart", 32'(bus.cipher_start), 32'd0);
        tick();
        chk("t1_c2_step", 32'(step_pulse), 32'd0);
        chk("t1_c2_cstart", 32'(bus.cipher_start), 32'd0);
        tick();
        chk("t1_c3_cstart", 32'(bus.cipher_start), 32'd1);
        tick();
        chk("t1_c4_cstart", 32'(bus.cipher_start), 32'd0);
        chk("t1_c4_out_valid", 32'(bus.out_valid), 32'd0);
        bus.cipher_done   = 1'b1;
        bus.cipher_result = 5'd1;
        tick();
        bus.cipher_done = 1'b0;
        chk("t1_c5_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_c5_out_letter", 32'(bus.out_letter), 32'd1);
        tick();
        chk("t1_c6_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_c6_busy", 32'(busy), 32'd0);
        chk("t1_count", 32'(letter_count), 32'd1);

        // Backpressure: ciphertext held for ten cycles; a new offer must be refused.
        bus.out_ready = 1'b0;
        run_to_wait(5'd3);
        bus.cipher_done   = 1'b1;
        bus.cipher_result = 5'd17;
        tick();
        bus.cipher_done   = 1'b0;
        bus.cipher_result = 5'd2;
        bus.in_valid      = 1'b1;
        bus.in_letter     = 5'd5;
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_out_letter", 32'(bus.out_letter), 32'd17);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_count", 32'(letter_count), 32'd1);
            tick();
        end
        chk("bp_cipher_letter", 32'(bus.cipher_letter), 32'd3);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_count", 32'(letter_count), 32'd2);
        tick();
        chk("bp_count_once", 32'(letter_count), 32'd2);
        chk("bp_idle_step", 32'(step_pulse), 32'd0);

        // Load priority over a simultaneous letter offer.
        load_req      = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_letter = 5'd7;
        #1 chk("ld_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("ld_load_pulse", 32'(load_pulse), 32'd1);
        chk("ld_no_step", 32'(step_pulse), 32'd0);
        load_req = 1'b0;
        tick();
        chk("ld_pulse_width", 32'(load_pulse), 32'd0);
        chk("ld_no_step2", 32'(step_pulse), 32'd0);
        chk("ld_count_clear", 32'(letter_count), 32'd0);
        chk("ld_in_ready_after", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("ld_accept_step", 32'(step_pulse), 32'd1);
        chk("ld_cipher_letter", 32'(bus.cipher_letter), 32'd7);
        tick();
        tick();
        tick();
        bus.cipher_done   = 1'b1;
        bus.cipher_result = 5'd9;
        tick();
        bus.cipher_done = 1'b0;
        chk("ld_out_letter", 32'(bus.out_letter), 32'd9);
        tick();
        chk("ld_count_after", 32'(letter_count), 32'd1);

        // Bad letters 26 and 31 are consumed with an error pulse each.
        bus.in_valid  = 1'b1;
        bus.in_letter = 5'd26;
        #1 chk("bad_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("bad26_err", 32'(err_letter), 32'd1);
        chk("bad26_busy", 32'(busy), 32'd0);
        chk("bad26_step", 32'(step_pulse), 32'd0);
        bus.in_letter = 5'd31;
        tick();
        bus.in_valid = 1'b0;
        chk("bad31_err", 32'(err_letter), 32'd1);
        chk("bad31_busy", 32'(busy), 32'd0);
        chk("bad31_step", 32'(step_pulse), 32'd0);
        tick();
        chk("bad_err_clear", 32'(err_letter), 32'd0);
        chk("bad_idle_busy", 32'(busy), 32'd0);
        chk("bad_cipher_letter", 32'(bus.cipher_letter), 32'd7);

        // Watchdog: eight WAIT cycles with no done.
        run_to_wait(5'd2);
        for (int w = 1; w <= 8; w++) begin
            chk("wd_busy", 32'(busy), 32'd1);
            chk("wd_err_early", 32'(err_timeout), 32'd0);
            chk("wd_out_valid", 32'(bus.out_valid), 32'd0);
            tick();
        end
        chk("wd_err_timeout", 32'(err_timeout), 32'd1);
        chk("wd_idle", 32'(busy), 32'd0);
        chk("wd_no_out", 32'(bus.out_valid), 32'd0);
        tick();
        chk("wd_err_width", 32'(err_timeout), 32'd0);
        chk("wd_no_out2", 32'(bus.out_valid), 32'd0);
        chk("wd_count", 32'(letter_count), 32'd1);

        // Done in the expiry cycle wins over the watchdog.
        run_to_wait(5'd4);
        for (int w = 1; w <= 8; w++) begin
            chk("wdd_busy", 32'(busy), 32'd1);
            if (w == 8) begin
                bus.cipher_done   = 1'b1;
                bus.cipher_result = 5'd20;
            end
            tick();
        end
        bus.cipher_done = 1'b0;
        chk("wdd_out_valid", 32'(bus.out_valid), 32'd1);
        chk("wdd_out_letter", 32'(bus.out_letter), 32'd20);
        chk("wdd_no_err", 32'(err_timeout), 32'd0);
        tick();
        chk("wdd_no_err2", 32'(err_timeout), 32'd0);
        chk("wdd_count", 32'(letter_count), 32'd2);

        // Asynchronous reset in the middle of WAIT.
        run_to_wait(5'd11);
        tick();
        chk("rw_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rw_out_letter", 32'(bus.out_letter), 32'd0);
        chk("rw_cipher_letter", 32'(bus.cipher_letter), 32'd0);
        chk("rw_count", 32'(letter_count), 32'd0);
        chk("rw_strobes", 32'({load_pulse, step_pulse, bus.cipher_start}), 32'd0);
        chk("rw_errs", 32'({err_letter, err_timeout}), 32'd0);
        chk("rw_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_to_wait(5'd25);
        bus.cipher_done   = 1'b1;
        bus.cipher_result = 5'd11;
        tick();
        bus.cipher_done = 1'b0;
        chk("rw_post_out_valid", 32'(bus.out_valid), 32'd1);
        chk("rw_post_out_letter", 32'(bus.out_letter), 32'd11);
        chk("rw_post_cipher_letter", 32'(bus.cipher_letter), 32'd25);
        tick();
        chk("rw_post_count", 32'(letter_count), 32'd1);
        chk("rw_post_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
